// File: rtl/ddr_arb_pkg.sv
// Purpose: shared command layout and helpers for the DDR command arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ddr_arb_pkg;

    localparam int CMD_W     = 34;
    localparam int RW_BIT    = 31;
    localparam int ROW_HI    = 29;
    localparam int ROW_LO    = 17;
    localparam int AP_BIT    = 13;
    localparam int COL_HI    = 12;
    localparam int COL_LO    = 3;
    localparam int BANK_HI   = 2;
    localparam int BANK_LO   = 0;
    localparam int NUM_BANKS = 8;

    // Controller command word; reserved bits are always driven 0 by the sources.
    typedef struct packed {
        logic [1:0]  rank;
        logic        rw;       // 0 = write, 1 = read
        logic        rsv0;
        logic [12:0] row;
        logic        rsv1;
        logic        bl;
        logic        rsv2;
        logic        auto_pre;
        logic [9:0]  col;
        logic [2:0]  bank;
    } cmd_t;

    function automatic logic [2:0] cmd_bank(input logic [CMD_W-1:0] c);
        return c[BANK_HI:BANK_LO];
    endfunction

    function automatic logic [12:0] cmd_row(input logic [CMD_W-1:0] c);
        return c[ROW_HI:ROW_LO];
    endfunction

    function automatic logic cmd_is_read(input logic [CMD_W-1:0] c);
        return c[RW_BIT];
    endfunction

    function automatic logic cmd_auto_pre(input logic [CMD_W-1:0] c);
        return c[AP_BIT];
    endfunction

    function automatic logic [9:0] cmd_col(input logic [CMD_W-1:0] c);
        return c[COL_HI:COL_LO];
    endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Purpose: in-order FIFO of requester ids for reads in flight.
// Latency: push visible at head next cycle; head is combinational from storage.
// Backpressure: caller must not push when full unless popping; pop on empty is ignored.
// Ports: clk/rst_n (sync active-low), push/push_data, pop/pop_data, full, empty, count.
module ddr_tag_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop & ~empty;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push  = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_cmd_arbiter.sv
// Purpose: shares one DDR controller command port among NUM_REQ sources and routes read data back.
// Latency: grant cycle t -> command/valid/write_data at t+1; read_data_valid t -> rsp_valid t+1.
// Backpressure: req_ready only to eligible sources (bank accepting, tag space for reads).
// Ports: req_valid/req_ready/req_cmd/req_wdata per source; ba_cmd_pm bank throttle;
//        command/valid/write_data to controller; read_data(_valid) from controller;
//        rsp_valid/rsp_data to sources; rd_outstanding count; sticky err_underflow.
module ddr_cmd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_W     = 128,
    parameter int TAG_DEPTH  = 16,
    parameter int STARVE_MAX = 8
) (
    input  logic                        clk,
    input  logic                        power_on_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*CMD_W-1:0]    req_cmd,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [7:0]                  ba_cmd_pm,
    output logic [CMD_W-1:0]            command,
    output logic                        valid,
    output logic [DATA_W-1:0]           write_data,
    input  logic [DATA_W-1:0]           read_data,
    input  logic                        read_data_valid,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(TAG_DEPTH):0]  rd_outstanding,
    output logic                        err_underflow
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    cmd_t              cmds [NUM_REQ];
    logic [DATA_W-1:0] wdat [NUM_REQ];

    logic              open_q [NUM_BANKS];
    logic [12:0]       row_q  [NUM_BANKS];
    logic [SW-1:0]     starve_q [NUM_REQ];
    logic [ID_W-1:0]   rr_q;

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] hit;

    logic              starve_found, hit_found, any_found;
    logic [ID_W-1:0]   starve_id, hit_id, any_id, idx;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_is_rd;

    logic              fifo_full, fifo_empty;
    logic [ID_W-1:0]   fifo_head;
    logic              rd_pop;

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            cmds[r] = cmd_t'(req_cmd[r*CMD_W +: CMD_W]);
            wdat[r] = req_wdata[r*DATA_W +: DATA_W];
        end
    end

    // Full is the pre-pop state, so a read never rides on a same-cycle return.
    always_comb begin
        elig = '0;
        hit  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            elig[r] = req_valid[r] & ba_cmd_pm[cmd_bank(cmds[r])]
                      & (~cmd_is_read(cmds[r]) | ~fifo_full);
            hit[r]  = elig[r] & open_q[cmd_bank(cmds[r])]
                      & (row_q[cmd_bank(cmds[r])] == cmd_row(cmds[r]));
        end
    end

    // Loops walk in reverse priority order so the highest-priority match is written last.
    always_comb begin
        starve_found = 1'b0;
        starve_id    = '0;
        hit_found    = 1'b0;
        hit_id       = '0;
        any_found    = 1'b0;
        any_id       = '0;
        idx          = '0;
        for (int r = NUM_REQ - 1; r >= 0; r--) begin
            if (elig[r] && starve_q[r] == STARVE_LIM) begin
                starve_found = 1'b1;
                starve_id    = ID_W'(r);
            end
        end
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (hit[idx]) begin
                hit_found = 1'b1;
                hit_id    = idx;
            end
            if (elig[idx]) begin
                any_found = 1'b1;
                any_id    = idx;
            end
        end
    end

    always_comb begin
        gnt_vld = power_on_rst_n & (starve_found | hit_found | any_found);
        if (starve_found) begin
            gnt_id = starve_id;
        end else if (hit_found) begin
            gnt_id = hit_id;
        end else begin
            gnt_id = any_id;
        end
        gnt_is_rd = gnt_vld & cmd_is_read(cmds[gnt_id]);
        req_ready = gnt_vld ? (NUM_REQ'(1) << gnt_id) : '0;
    end

    assign rd_pop = read_data_valid & ~fifo_empty;

    ddr_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (power_on_rst_n),
        .push      (gnt_is_rd),
        .push_data (gnt_id),
        .pop       (rd_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rd_outstanding)
    );

    always_ff @(posedge clk) begin
        if (!power_on_rst_n) begin
            command       <= '0;
            valid         <= 1'b0;
            write_data    <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            err_underflow <= 1'b0;
            rr_q          <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                open_q[b] <= 1'b0;
                row_q[b]  <= '0;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
                starve_q[r] <= '0;
            end
        end else begin
            valid      <= gnt_vld;
            command    <= gnt_vld ? CMD_W'(cmds[gnt_id]) : '0;
            write_data <= (gnt_vld && !gnt_is_rd) ? wdat[gnt_id] : '0;

            if (gnt_vld) begin
                rr_q <= gnt_id;
                if (cmd_auto_pre(cmds[gnt_id])) begin
                    open_q[cmd_bank(cmds[gnt_id])] <= 1'b0;
                end else begin
                    open_q[cmd_bank(cmds[gnt_id])] <= 1'b1;
                    row_q[cmd_bank(cmds[gnt_id])]  <= cmd_row(cmds[gnt_id]);
                end
            end

            for (int r = 0; r < NUM_REQ; r++) begin
                if (gnt_vld && gnt_id == ID_W'(r)) begin
                    starve_q[r] <= '0;
                end else if (elig[r] && starve_q[r] != STARVE_LIM) begin
                    starve_q[r] <= starve_q[r] + 1'b1;
                end
            end

            // Data with no owner is dropped; rsp_data keeps the last delivered beat.
            rsp_valid <= rd_pop ? (NUM_REQ'(1) << fifo_head) : '0;
            if (rd_pop) begin
                rsp_data <= read_data;
            end
            if (read_data_valid && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
module tb_ddr_cmd_arbiter;

    localparam int N  = 2;
    localparam int DW = 128;
    localparam int TD = 16;
    localparam int SM = 8;
    localparam int CW = 34;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*CW-1:0] req_cmd;
    logic [N*DW-1:0] req_wdata;
    logic [7:0]      ba_cmd_pm;
    logic [CW-1:0]   command;
    logic            valid;
    logic [DW-1:0]   write_data;
    logic [DW-1:0]   read_data;
    logic            read_data_valid;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [$clog2(TD):0] rd_outstanding;
    logic            err_underflow;

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .TAG_DEPTH(TD), .STARVE_MAX(SM)
    ) dut (
        .clk            (clk),
        .power_on_rst_n (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_wdata      (req_wdata),
        .ba_cmd_pm      (ba_cmd_pm),
        .command        (command),
        .valid          (valid),
        .write_data     (write_data),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rd_outstanding (rd_outstanding),
        .err_underflow  (err_underflow)
    );

    // Stimulus staging
    logic [CW-1:0] cmd_a [N];
    logic [DW-1:0] wd_a  [N];

    // Reference model state
    int          tagq [$];
    bit          open_m [8];
    logic [12:0] row_m  [8];
    int          starve_m [N];
    int          rr_m;
    bit          elig_m [N];
    logic [CW-1:0] e_cmd;
    logic          e_vld;
    logic [DW-1:0] e_wd;
    logic [N-1:0]  e_rspv;
    logic [DW-1:0] e_rspd;
    logic          e_err;

    int n_assert = 0;
    int n_fail   = 0;
    int gcnt [N];
    int rcnt [N];
    int last_g;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CW-1:0] mk(input bit rw, input int row, input bit ap,
                                         input int bank, input int col);
        logic [12:0] r13;
        logic [9:0]  c10;
        logic [2:0]  b3;
        r13 = row[12:0];
        c10 = col[9:0];
        b3  = bank[2:0];
        return {2'b00, rw, 1'b0, r13, 1'b0, 1'b0, 1'b0, ap, c10, b3};
    endfunction

    task automatic set_req(input int r, input bit v, input bit rw, input int row,
                           input bit ap, input int bank, input logic [DW-1:0] d);
        req_valid[r] = v;
        cmd_a[r]     = mk(rw, row, ap, bank, row + 3);
        wd_a[r]      = d;
    endtask

    // Spec rules: forced win for a saturated starver (lowest index), else
    // first row hit after the last grantee, else first eligible after it.
    task automatic model_grant(output bit gf, output int g);
        bit          hit [N];
        logic [2:0]  b;
        int          idx;
        gf = 0;
        g  = 0;
        for (int r = 0; r < N; r++) begin
            b = cmd_a[r][2:0];
            elig_m[r] = rst_n && req_valid[r] && ba_cmd_pm[b]
                        && (!cmd_a[r][31] || tagq.size() < TD);
            hit[r] = elig_m[r] && open_m[b] && (row_m[b] == cmd_a[r][29:17]);
        end
        for (int r = 0; r < N; r++) begin
            if (!gf && elig_m[r] && starve_m[r] == SM) begin gf = 1; g = r; end
        end
        for (int k = 1; k <= N; k++) begin
            idx = (rr_m + k) % N;
            if (!gf && hit[idx]) begin gf = 1; g = idx; end
        end
        for (int k = 1; k <= N; k++) begin
            idx = (rr_m + k) % N;
            if (!gf && elig_m[idx]) begin gf = 1; g = idx; end
        end
    endtask

    task automatic model_clock(input bit gf, input int g);
        logic [2:0] b;
        int         id;
        if (!rst_n) begin
            tagq.delete();
            for (int i = 0; i < 8; i++) begin open_m[i] = 0; row_m[i] = '0; end
            for (int r = 0; r < N; r++) starve_m[r] = 0;
            rr_m = 0; e_cmd = '0; e_vld = 0; e_wd = '0; e_rspv = '0; e_rspd = '0; e_err = 0;
            return;
        end
        e_vld = gf;
        e_cmd = gf ? cmd_a[g] : '0;
        e_wd  = (gf && !cmd_a[g][31]) ? wd_a[g] : '0;
        for (int r = 0; r < N; r++) begin
            if (gf && r == g) starve_m[r] = 0;
            else if (elig_m[r] && starve_m[r] < SM) starve_m[r]++;
        end
        e_rspv = '0;
        if (read_data_valid) begin
            if (tagq.size() > 0) begin
                id = tagq.pop_front();
                e_rspv = N'(1) << id;
                e_rspd = read_data;
            end else begin
                e_err = 1;
            end
        end
        if (gf) begin
            rr_m = g;
            b = cmd_a[g][2:0];
            if (cmd_a[g][13]) open_m[b] = 0;
            else begin open_m[b] = 1; row_m[b] = cmd_a[g][29:17]; end
            if (cmd_a[g][31]) tagq.push_back(g);
        end
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic cycle();
        bit gf;
        int g;
        for (int r = 0; r < N; r++) begin
            req_cmd[r*CW +: CW]   = cmd_a[r];
            req_wdata[r*DW +: DW] = wd_a[r];
        end
        #1;
        model_grant(gf, g);
        chk("req_ready", req_ready, gf ? (N'(1) << g) : '0);
        last_g = -1;
        for (int r = 0; r < N; r++) begin
            if (req_ready[r]) begin gcnt[r]++; last_g = r; end
        end
        @(posedge clk);
        #1;
        model_clock(gf, g);
        chk("valid", valid, e_vld);
        chk("command", command, e_cmd);
        chk("write_data", write_data, e_wd);
        chk("rsp_valid", rsp_valid, e_rspv);
        chk("rsp_data", rsp_data, e_rspd);
        chk("rd_outstanding", rd_outstanding, tagq.size());
        chk("err_underflow", err_underflow, e_err);
        for (int r = 0; r < N; r++) if (rsp_valid[r]) rcnt[r]++;
        @(negedge clk);
    endtask

    task automatic idle_all();
        req_valid = '0;
        read_data_valid = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 0;
        cycle();
        cycle();
        rst_n = 1;
    endtask

    logic [DW-1:0] mem [4];
    int wins;
    int seq [6];

    initial begin
        rst_n = 0; req_valid = '0; req_cmd = '0; req_wdata = '0;
        ba_cmd_pm = 8'hFF; read_data = '0; read_data_valid = 0;
        for (int r = 0; r < N; r++) begin
            cmd_a[r] = '0; wd_a[r] = '0; gcnt[r] = 0; rcnt[r] = 0; starve_m[r] = 0;
        end
        rr_m = 0;

        // Reset state
        do_reset();
        chk("reset_valid", valid, 1'b0);
        chk("reset_err", err_underflow, 1'b0);

        // Single requester: write bank0 rows 0..3, read them back
        for (int i = 0; i < 4; i++) begin
            mem[i] = {4{32'hA000_0000 + 32'(i)}};
            set_req(0, 1, 0, i, 1, 0, mem[i]);
            cycle();
            chk("wr_grant_req0", last_g, 0);
        end
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1, 1, i, 1, 0, '1);
            cycle();
            chk("rd_grant_req0", last_g, 0);
        end
        idle_all();
        cycle();
        chk("rd_outstanding_4", rd_outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            read_data_valid = 1; read_data = mem[i];
            cycle();
            chk("rsp_data_match", rsp_data, mem[i]);
        end
        idle_all();
        cycle();
        chk("rsp_count_req0", rcnt[0], 4);
        chk("rd_outstanding_0", rd_outstanding, 0);

        // Two requesters, no row hits: grants alternate
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1, 0, 10 + i, 1, 1, DW'(i));
            set_req(1, 1, 0, 100 + i, 1, 2, DW'(i + 50));
            cycle();
            seq[i] = last_g;
        end
        for (int i = 1; i < 6; i++) chk("alternate", seq[i], 1 - seq[i-1]);

        // Row hit favoured until the starve bound forces req1 in
        do_reset();
        set_req(0, 1, 0, 5, 0, 0, DW'(5));
        cycle();
        wins = 0;
        set_req(0, 1, 0, 5, 0, 0, DW'(55));
        set_req(1, 1, 0, 9, 0, 0, DW'(99));
        for (int i = 0; i < 20 && req_valid[1]; i++) begin
            cycle();
            if (last_g == 0) wins++;
            if (last_g == 1) req_valid[1] = 0;
        end
        chk("hit_wins_before_starve", wins, SM);
        chk("req1_granted", req_valid[1], 1'b0);
        cycle();
        chk("rr_after_starve", last_g, 0);

        // Bank throttle blocks req0 only
        idle_all();
        for (int r = 0; r < N; r++) gcnt[r] = 0;
        ba_cmd_pm = 8'hFB;
        for (int i = 0; i < 8; i++) begin
            set_req(0, 1, 0, i, 1, 2, DW'(i));
            set_req(1, 1, 0, i, 1, 3, DW'(i + 7));
            cycle();
        end
        chk("pm_block_req0", gcnt[0], 0);
        chk("pm_pass_req1", gcnt[1], 8);
        ba_cmd_pm = 8'hFF;

        // Tag FIFO fills at 16; writes keep flowing
        do_reset();
        for (int i = 0; i < TD; i++) begin
            set_req(0, 1, 1, i, 1, 1, '0);
            cycle();
        end
        chk("rd_full_16", rd_outstanding, TD);
        for (int r = 0; r < N; r++) gcnt[r] = 0;
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1, 0, i, 1, 3, DW'(i + 200));
            cycle();
        end
        chk("full_blocks_read", gcnt[0], 0);
        chk("full_write_flows", gcnt[1], 4);
        req_valid[1] = 0;
        read_data_valid = 1; read_data = DW'(32'h1111);
        cycle();
        chk("pop_while_full", rd_outstanding, TD - 1);
        read_data = DW'(32'h2222);
        cycle();
        chk("push_pop_same", rd_outstanding, TD - 1);
        read_data_valid = 0;
        cycle();
        chk("refill_16", rd_outstanding, TD);

        // Underflow is sticky until reset
        do_reset();
        read_data_valid = 1; read_data = DW'(32'hDEAD);
        cycle();
        chk("underflow_set", err_underflow, 1'b1);
        chk("underflow_drop", rsp_valid, '0);
        read_data_valid = 0;
        cycle();
        chk("underflow_sticky", err_underflow, 1'b1);
        do_reset();
        chk("underflow_cleared", err_underflow, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            for (int r = 0; r < N; r++) begin
                set_req(r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom});
            end
            for (int b = 0; b < 8; b++) ba_cmd_pm[b] = ($urandom_range(0, 7) != 0);
            read_data_valid = ($urandom_range(0, 2) == 0);
            read_data = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
